// File: rtl/conv_result_streamer.sv
// conv_result_streamer
// Captures the flattened convolve result bus when the engine signals completion and
// streams the words out over a valid/ready handshake. It also reports the word index,
// the peak absolute value seen in the frame and a sticky overrun flag.
module conv_result_streamer #(
    parameter int LEN             = 19,
    parameter int SIGNAL_LENGTH_1 = 2400,
    parameter int SHIFT           = 0,
    localparam int NUM_OUT        = LEN + SIGNAL_LENGTH_1 + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 conv_done,
    input  logic [NUM_OUT*16:0]  conv_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic [11:0]          out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          peak_abs,
    output logic                 overrun
);

    localparam int          IW       = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [11:0] LAST_IDX = 12'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        STREAM,
        DONE_ST
    } state_t;

    state_t      state;
    logic        done_d1;
    logic        done_d2;
    logic        rise;
    logic [15:0] in_word  [NUM_OUT];
    logic [15:0] word_buf [NUM_OUT];
    logic [15:0] cur_word;
    logic [15:0] cur_abs;
    logic [11:0] next_index;
    logic [15:0] next_word;
    logic        unused_msb;

    // The top bit of the flat bus carries no data.
    assign unused_msb = conv_flat[NUM_OUT*16];

    // Slice the flat bus into individual words.
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slice
        assign in_word[gi] = conv_flat[gi*16 +: 16];
    end

    // A frame starts only on a 0->1 transition of the registered completion flag.
    assign rise = done_d1 & ~done_d2;

    assign next_index = out_index + 12'd1;
    assign next_word  = word_buf[next_index[IW-1:0]];

    // |cur_word| with the most negative value saturated so it fits in 15 magnitude bits.
    assign cur_abs = (cur_word == 16'h8000) ? 16'h7FFF :
                     (cur_word[15] ? 16'(~cur_word + 16'd1) : cur_word);

    function automatic logic [15:0] shift_word(input logic [15:0] w);
        return 16'($signed(w) >>> SHIFT);
    endfunction

    // Two-stage registered copy of conv_done for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_d1 <= 1'b0;
            done_d2 <= 1'b0;
        end else begin
            done_d1 <= conv_done;
            done_d2 <= done_d1;
        end
    end

    // Capture buffer: loaded from the flat bus only during the single CAPTURE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                word_buf[i] <= 16'd0;
            end
        end else if (state == CAPTURE) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                word_buf[i] <= in_word[i];
            end
        end
    end

    // Frame FSM with registered outputs; cur_word tracks the unshifted word on out_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= 16'd0;
            out_index <= 12'd0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            peak_abs  <= 16'd0;
            overrun   <= 1'b0;
            cur_word  <= 16'd0;
        end else begin
            // Any rise outside IDLE (busy or in the DONE cycle) is an overrun and is dropped.
            if (rise && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (rise) begin
                        busy  <= 1'b1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    cur_word  <= in_word[0];
                    out_data  <= shift_word(in_word[0]);
                    out_index <= 12'd0;
                    out_last  <= (LAST_IDX == 12'd0);
                    out_valid <= 1'b1;
                    peak_abs  <= 16'd0;
                    state     <= STREAM;
                end
                STREAM: begin
                    // out_valid is always high here, so out_ready alone completes a handshake.
                    if (out_ready) begin
                        if (cur_abs > peak_abs) begin
                            peak_abs <= cur_abs;
                        end
                        if (out_index == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE_ST;
                        end else begin
                            out_index <= next_index;
                            cur_word  <= next_word;
                            out_data  <= shift_word(next_word);
                            out_last  <= (next_index == LAST_IDX);
                        end
                    end
                end
                DONE_ST: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
